// File: rtl/rv_pkg.sv
// Shared fetch-stage definitions: data widths, reset/bubble defaults,
// fetch FSM state encoding and the {instr,pc} payload held by the skid buffer.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] WORD_MASK     = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] PC_STEP       = 32'h0000_0004;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // nothing outstanding
    S_WAIT = 2'd1,  // one request outstanding, response wanted
    S_DROP = 2'd2   // one request outstanding, response is wrong-path
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetched {instr,pc} that arrived while
// decode was stalled.
//   clk, reset : clock, synchronous active-high reset
//   i_load     : capture i_entry and mark the entry valid
//   i_clear    : drop the entry (wins over i_load)
//   i_entry    : payload to capture
//   o_entry    : held payload
//   o_valid    : entry is full
module if_skid_buffer
  import rv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  fetch_entry_t i_entry,
  output fetch_entry_t o_entry,
  output logic         o_valid
);

  fetch_entry_t r_entry;
  logic         r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end
  end

  assign o_entry = r_entry;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the fetch PC, runs the imem
// req/gnt/rvalid handshake (one request outstanding at most) and drives the
// IF/ID register. Honors decode stall (IFWrite) and redirect (Branch/Jump).
//   clk, reset      : clock, synchronous active-high reset
//   IFWrite         : 0 = hold PC and IF/ID (stall)
//   Branch, Jump    : redirect request from decode, target on JumpAddr
//   imem_req/addr   : fetch request and word-aligned byte address
//   imem_gnt        : request accepted this cycle
//   imem_rvalid/rdata : response for the outstanding request
//   Instruction_id, PC_id, Valid_id : IF/ID register
module if_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IFWrite,
  input  logic            Branch,
  input  logic            Jump,
  input  logic [XLEN-1:0] JumpAddr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] Instruction_id,
  output logic [XLEN-1:0] PC_id,
  output logic            Valid_id
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_instr_id;
  logic [XLEN-1:0] r_pc_id;
  logic            r_valid_id;

  logic            w_redirect;
  logic            w_req;
  logic            w_fire;
  logic            w_take;
  logic            w_skid_load;
  logic            w_skid_clear;
  logic            w_skid_valid;
  fetch_entry_t    w_skid_in;
  fetch_entry_t    w_skid_out;

  // A stall masks the redirect; decode re-evaluates the branch afterwards.
  assign w_redirect = (Branch | Jump) & IFWrite;

  // Next-state and request generation.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_take      = 1'b0;
    w_skid_load = 1'b0;
    case (r_state)
      S_REQ: begin
        w_req = ~w_redirect & ~w_skid_valid;
        if (w_req && imem_gnt) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (w_redirect) begin
            w_state_nxt = S_REQ;
          end else if (!IFWrite) begin
            w_skid_load = 1'b1;
            w_state_nxt = S_REQ;
          end else begin
            // Response goes straight to IF/ID; overlap the next request.
            w_take      = ~w_skid_valid;
            w_req       = ~w_skid_valid;
            w_state_nxt = (w_req && imem_gnt) ? S_WAIT : S_REQ;
          end
        end else if (w_redirect) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  assign imem_req  = w_req & ~reset;
  assign imem_addr = r_fetch_pc;
  assign w_fire    = imem_req & imem_gnt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_REQ;
    else       r_state <= w_state_nxt;
  end

  // Fetch PC and PC of the outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else if (w_redirect) begin
      r_fetch_pc <= JumpAddr & WORD_MASK;
    end else if (w_fire) begin
      r_fetch_pc <= r_fetch_pc + PC_STEP;
      r_req_pc   <= r_fetch_pc;
    end
  end

  // Skid drains whenever decode accepts; a redirect discards it.
  assign w_skid_clear = w_redirect | (IFWrite & w_skid_valid);
  assign w_skid_in    = '{instr: imem_rdata, pc: r_req_pc};

  if_skid_buffer u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_entry (w_skid_in),
    .o_entry (w_skid_out),
    .o_valid (w_skid_valid)
  );

  // IF/ID register: redirect bubble > skid > fresh response > bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_id <= NOP_INSTR;
      r_pc_id    <= RESET_PC;
      r_valid_id <= 1'b0;
    end else if (IFWrite) begin
      if (w_redirect) begin
        r_instr_id <= NOP_INSTR;
        r_valid_id <= 1'b0;
      end else if (w_skid_valid) begin
        r_instr_id <= w_skid_out.instr;
        r_pc_id    <= w_skid_out.pc;
        r_valid_id <= 1'b1;
      end else if (w_take) begin
        r_instr_id <= imem_rdata;
        r_pc_id    <= r_req_pc;
        r_valid_id <= 1'b1;
      end else begin
        r_instr_id <= NOP_INSTR;
        r_valid_id <= 1'b0;
      end
    end
  end

  assign Instruction_id = r_instr_id;
  assign PC_id          = r_pc_id;
  assign Valid_id       = r_valid_id;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a behavioural instruction memory (content is a
// hash of the address, one response per grant after a programmable latency),
// directed scenarios with fixed expectations, and a randomized run checked
// against a program-order model of the fetch stream.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        IFWrite, Branch, Jump;
  logic [31:0] JumpAddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction_id, PC_id;
  logic        Valid_id;

  int n_checks = 0;
  int n_errors = 0;

  // memory model state
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          mem_lat;
  bit          gnt_en;

  // combinational outputs sampled mid-cycle
  logic        s_req;
  logic [31:0] s_addr;

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .IFWrite        (IFWrite),
    .Branch         (Branch),
    .Jump           (Jump),
    .JumpAddr       (JumpAddr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .Instruction_id (Instruction_id),
    .PC_id          (PC_id),
    .Valid_id       (Valid_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // One clock: drive memory response, sample comb outputs, take the edge.
  task automatic cyc();
    imem_rvalid = mem_pend && (mem_cnt == 0) && !reset;
    imem_rdata  = imem_rvalid ? memf(mem_addr) : $urandom;
    imem_gnt    = gnt_en;
    #1;
    s_req  = imem_req;
    s_addr = imem_addr;
    @(posedge clk);
    if (reset) mem_pend = 1'b0;
    else begin
      if (imem_rvalid) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (s_req && imem_gnt) begin
        mem_pend = 1'b1;
        mem_addr = s_addr;
        mem_cnt  = mem_lat - 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; IFWrite = 1'b1; Branch = 1'b0; Jump = 1'b0; JumpAddr = '0;
    gnt_en = 1'b1; mem_lat = 1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; IFWrite = 1'b1; Branch = 1'b0; Jump = 1'b0; JumpAddr = '0;
    gnt_en = 1'b1; mem_lat = 1; mem_pend = 1'b0;
    cyc();
    n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", s_req); end
    n_checks++; if (Instruction_id !== NOP) begin n_errors++; $display("FAIL reset_instr: got %h want %h", Instruction_id, NOP); end
    n_checks++; if (PC_id !== RST) begin n_errors++; $display("FAIL reset_pc: got %h want %h", PC_id, RST); end
    n_checks++; if (Valid_id !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", Valid_id); end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_checks++; if (s_req !== 1'b1 || s_addr !== 32'(4 * k)) begin
        n_errors++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", k, s_req, s_addr, 32'(4 * k));
      end
      if (k == 0) begin
        n_checks++; if (Valid_id !== 1'b0) begin n_errors++; $display("FAIL stream_first_bubble: got %b want 0", Valid_id); end
      end else begin
        n_checks++; if (Valid_id !== 1'b1 || PC_id !== 32'(4 * (k - 1)) || Instruction_id !== memf(32'(4 * (k - 1)))) begin
          n_errors++; $display("FAIL stream_ifid[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", k, Valid_id, PC_id,
                               Instruction_id, 32'(4 * (k - 1)), memf(32'(4 * (k - 1))));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    cyc(); cyc(); cyc();
    n_checks++; if (PC_id !== 32'h4) begin n_errors++; $display("FAIL stall_pre_pc: got %h want 4", PC_id); end
    for (int k = 0; k < 3; k++) begin
      IFWrite = 1'b0;
      cyc();
      n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL stall_req[%0d]: got %b want 0", k, s_req); end
      n_checks++; if (PC_id !== 32'h4 || Valid_id !== 1'b1 || Instruction_id !== memf(32'h4)) begin
        n_errors++; $display("FAIL stall_hold[%0d]: got pc=%h v=%b want pc=4 v=1", k, PC_id, Valid_id);
      end
    end
    IFWrite = 1'b1;
    cyc();
    n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL stall_drain_req: got %b want 0", s_req); end
    n_checks++; if (PC_id !== 32'h8 || Valid_id !== 1'b1 || Instruction_id !== memf(32'h8)) begin
      n_errors++; $display("FAIL stall_release: got pc=%h v=%b ins=%h want pc=8 v=1 ins=%h", PC_id, Valid_id, Instruction_id, memf(32'h8));
    end
    cyc();
    n_checks++; if (s_req !== 1'b1 || s_addr !== 32'hC) begin
      n_errors++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=c", s_req, s_addr);
    end
  endtask

  task automatic test_jump();
    do_reset();
    cyc(); cyc(); cyc(); cyc();
    mem_lat = 3;
    cyc();
    n_checks++; if (PC_id !== 32'hC || s_addr !== 32'h10) begin
      n_errors++; $display("FAIL jump_setup: got pc=%h addr=%h want pc=c addr=10", PC_id, s_addr);
    end
    Jump = 1'b1; JumpAddr = 32'h100;
    cyc();
    Jump = 1'b0;
    n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL jump_req_in_redirect: got %b want 0", s_req); end
    n_checks++; if (Valid_id !== 1'b0 || Instruction_id !== NOP || PC_id !== 32'hC) begin
      n_errors++; $display("FAIL jump_bubble: got v=%b ins=%h pc=%h want v=0 ins=%h pc=c", Valid_id, Instruction_id, PC_id, NOP);
    end
    cyc();
    n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL jump_drop_wait: got req=%b want 0", s_req); end
    cyc();
    n_checks++; if (s_req !== 1'b0 || Valid_id !== 1'b0) begin
      n_errors++; $display("FAIL jump_drop_resp: got req=%b v=%b want req=0 v=0", s_req, Valid_id);
    end
    mem_lat = 1;
    cyc();
    n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin
      n_errors++; $display("FAIL jump_target_req: got req=%b addr=%h want req=1 addr=100", s_req, s_addr);
    end
    cyc();
    n_checks++; if (Valid_id !== 1'b1 || PC_id !== 32'h100 || Instruction_id !== memf(32'h100)) begin
      n_errors++; $display("FAIL jump_target_ifid: got v=%b pc=%h want v=1 pc=100", Valid_id, PC_id);
    end
  endtask

  task automatic test_branch_stalled();
    do_reset();
    cyc();
    IFWrite = 1'b0; Branch = 1'b1; JumpAddr = 32'h200;
    cyc();
    n_checks++; if (Valid_id !== 1'b0 || PC_id !== RST) begin
      n_errors++; $display("FAIL bstall_hold: got v=%b pc=%h want v=0 pc=0", Valid_id, PC_id);
    end
    IFWrite = 1'b1; Branch = 1'b0;
    cyc();
    n_checks++; if (Valid_id !== 1'b1 || PC_id !== 32'h0 || Instruction_id !== memf(32'h0)) begin
      n_errors++; $display("FAIL bstall_not_flushed: got v=%b pc=%h want v=1 pc=0", Valid_id, PC_id);
    end
    cyc();
    n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h4) begin
      n_errors++; $display("FAIL bstall_pc: got req=%b addr=%h want req=1 addr=4", s_req, s_addr);
    end
  endtask

  task automatic test_gnt_low();
    do_reset();
    gnt_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_checks++; if (s_req !== 1'b1 || s_addr !== RST) begin
        n_errors++; $display("FAIL gnt_low_req[%0d]: got req=%b addr=%h want req=1 addr=0", k, s_req, s_addr);
      end
      n_checks++; if (Valid_id !== 1'b0 || Instruction_id !== NOP) begin
        n_errors++; $display("FAIL gnt_low_bubble[%0d]: got v=%b ins=%h", k, Valid_id, Instruction_id);
      end
    end
    gnt_en = 1'b1;
    cyc(); cyc();
    n_checks++; if (Valid_id !== 1'b1 || PC_id !== RST || Instruction_id !== memf(RST)) begin
      n_errors++; $display("FAIL gnt_low_after: got v=%b pc=%h want v=1 pc=0", Valid_id, PC_id);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    cyc();
    Jump = 1'b1; JumpAddr = 32'hFFFF_FFFF;
    cyc();
    Jump = 1'b0;
    n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL wrap_redirect_req: got %b want 0", s_req); end
    cyc();
    n_checks++; if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
      n_errors++; $display("FAIL wrap_target: got req=%b addr=%h want req=1 addr=fffffffc", s_req, s_addr);
    end
    mem_lat = 3;
    cyc();
    n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      n_errors++; $display("FAIL wrap_addr: got req=%b addr=%h want req=1 addr=0", s_req, s_addr);
    end
    n_checks++; if (Valid_id !== 1'b1 || PC_id !== 32'hFFFF_FFFC) begin
      n_errors++; $display("FAIL wrap_ifid: got v=%b pc=%h want v=1 pc=fffffffc", Valid_id, PC_id);
    end
    reset = 1'b1;
    cyc();
    n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL midreset_req: got %b want 0", s_req); end
    reset = 1'b0; mem_lat = 1;
    cyc();
    n_checks++; if (s_req !== 1'b1 || s_addr !== RST) begin
      n_errors++; $display("FAIL midreset_addr: got req=%b addr=%h want req=1 addr=%h", s_req, s_addr, RST);
    end
    n_checks++; if (Valid_id !== 1'b0 || PC_id !== RST) begin
      n_errors++; $display("FAIL midreset_ifid: got v=%b pc=%h want v=0 pc=0", Valid_id, PC_id);
    end
  endtask

  // Program-order model: each valid IF/ID entry must be the next sequential
  // address (or the last redirect target) carrying that address's memory word.
  task automatic test_random();
    logic [31:0] exp_req, exp_next, p_instr, p_pc, tgt;
    logic        p_valid, redir;
    bit          busy;
    int          nvalid = 0;
    do_reset();
    exp_req = RST; exp_next = RST;
    for (int i = 0; i < 3000; i++) begin
      IFWrite = ($urandom_range(0, 4) != 0);
      Branch  = ($urandom_range(0, 19) == 0);
      Jump    = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) JumpAddr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           JumpAddr = $urandom & 32'h0000_0FFF;
      gnt_en  = ($urandom_range(0, 9) < 7);
      mem_lat = $urandom_range(1, 3);
      redir   = IFWrite & (Branch | Jump);
      tgt     = JumpAddr & 32'hFFFF_FFFC;
      p_instr = Instruction_id; p_pc = PC_id; p_valid = Valid_id;
      busy    = mem_pend && (mem_cnt != 0);
      cyc();
      if (s_req) begin
        n_checks++; if (s_addr !== exp_req) begin
          n_errors++; $display("FAIL rnd_req_addr @%0d: got %h want %h", i, s_addr, exp_req);
        end
      end
      if (redir) begin
        n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL rnd_req_on_redirect @%0d: got %b want 0", i, s_req); end
      end
      if (s_req && busy) begin
        n_checks++; n_errors++; $display("FAIL rnd_two_outstanding @%0d: got req=1 want 0", i);
      end
      if (s_req && imem_gnt) exp_req = exp_req + 32'd4;
      if (redir) exp_req = tgt;
      n_checks++;
      if (!IFWrite) begin
        if (Instruction_id !== p_instr || PC_id !== p_pc || Valid_id !== p_valid) begin
          n_errors++; $display("FAIL rnd_stall_hold @%0d: got v=%b pc=%h want v=%b pc=%h", i, Valid_id, PC_id, p_valid, p_pc);
        end
      end else if (redir) begin
        if (Valid_id !== 1'b0 || Instruction_id !== NOP || PC_id !== p_pc) begin
          n_errors++; $display("FAIL rnd_flush @%0d: got v=%b ins=%h pc=%h want v=0 ins=%h pc=%h", i, Valid_id, Instruction_id, PC_id, NOP, p_pc);
        end
        exp_next = tgt;
      end else if (Valid_id === 1'b1) begin
        if (PC_id !== exp_next || Instruction_id !== memf(exp_next)) begin
          n_errors++; $display("FAIL rnd_order @%0d: got pc=%h ins=%h want pc=%h ins=%h", i, PC_id, Instruction_id, exp_next, memf(exp_next));
        end
        exp_next = exp_next + 32'd4;
        nvalid++;
      end else if (Valid_id !== 1'b0 || Instruction_id !== NOP) begin
        n_errors++; $display("FAIL rnd_bubble @%0d: got v=%b ins=%h want v=0 ins=%h", i, Valid_id, Instruction_id, NOP);
      end
    end
    Branch = 1'b0; Jump = 1'b0; IFWrite = 1'b1;
    n_checks++; if (nvalid < 200) begin n_errors++; $display("FAIL rnd_progress: got %0d valid want >= 200", nvalid); end
  endtask

  initial begin
    reset = 1'b1; IFWrite = 1'b1; Branch = 1'b0; Jump = 1'b0; JumpAddr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_pend = 1'b0; mem_addr = '0; mem_cnt = 0; mem_lat = 1; gnt_en = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_branch_stalled();
    test_gnt_low();
    test_wrap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
